avalon_st_msg_tx: RTL
=====================

Name: avalon_st_msg_tx

Overview:
Avalon-ST source (transmitter) that serialises one whole message per handshake onto an Avalon-ST stream with ready/valid, startofpacket/endofpacket, empty and error. The stream signal set and widths match the team's avalon_if bundle. The block drives the stream side that the decoder's sink consumes. It is used by stimulus/loopback paths and by the order-path egress, where a message assembled in parallel is streamed out 8 bytes per beat. Protocol settings are readyLatency 0 and big-endian symbol order: byte 0 of the message is in data[63:56] of the first beat.

Parameters:
DATA_WIDTH, 64, stream data width in bits; must equal 8 * 2**EMPTY_WIDTH.
EMPTY_WIDTH, 3, empty field width.
MAX_BYTES, 64, maximum message length in bytes; must be a multiple of DATA_WIDTH/8.
LEN_W, 7, width of msg_len; must hold MAX_BYTES.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
msg_valid  in  1  message offered
msg_ready  out  1  block can capture a message
msg_data  in  MAX_BYTES*8  message bytes; byte i = msg_data[8i+7:8i]
msg_len  in  LEN_W  message length in bytes
msg_error  in  1  mark packet errored
out_valid  out  1  Avalon-ST valid
out_ready  in  1  Avalon-ST ready from sink
out_startofpacket  out  1  first beat of packet
out_endofpacket  out  1  last beat of packet
out_data  out  DATA_WIDTH  beat data
out_empty  out  EMPTY_WIDTH  unused bytes in last beat
out_error  out  1  packet error, on eop beat only
drop_pulse  out  1  one-cycle pulse when an illegal-length message is discarded
busy  out  1  high in SEND

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - out_valid, out_startofpacket, out_endofpacket, out_error, drop_pulse and busy are 0.
  - out_data and out_empty are 0.
  - msg_ready is 1 once reset is released.
- States:
  - IDLE: msg_ready = 1.
  - SEND: msg_ready = 0.
- Capture, in IDLE when msg_valid=1:
  - Legal length (1 <= msg_len <= MAX_BYTES):
    - Register msg_data, msg_len and msg_error.
    - Compute beats = ceil(msg_len/8), beat_idx = 0.
    - Go to SEND.
  - Illegal length (msg_len = 0 or msg_len > MAX_BYTES):
    - Do not capture; stay in IDLE.
    - drop_pulse = 1 on the next cycle.
- SEND, beat k:
  - out_valid = 1.
  - out_data byte lane j (data[63-8j -: 8]) = message byte 8k+j when 8k+j < msg_len, else 0.
  - out_startofpacket = (k == 0).
  - out_endofpacket = (k == beats-1).
  - out_empty = beats*8 - msg_len on the eop beat, else 0.
  - out_error = captured msg_error on the eop beat, else 0.
- Latency: the first beat is presented in the cycle after capture. A beat is transferred when out_valid && out_ready.
- Backpressure:
  - When out_ready=0, all out_* hold stable.
  - out_valid never deasserts without a transfer.
- Beat transfer:
  - On a non-last beat: beat_idx increments.
  - On the last beat: return to IDLE; out_valid = 0 next cycle.
  - There is one idle cycle between packets. Minimum packet period is beats+1 cycles.
- A single-beat message has sop and eop both set on the same beat.
- A 64-byte message is 8 beats with empty = 0.
- beat_idx never wraps beyond beats-1.
- busy = (state == SEND).
- Reset mid-packet:
  - Immediately drops out_valid, sop and eop.
  - The packet is abandoned; no eop is emitted.
  - After release, the block accepts a new message.
- out_ready is ignored when out_valid = 0.

Test Plan:
- msg_len=20, bytes 0x00..0x13, out_ready=1 -> 3 beats on consecutive cycles:
  - beat0 = 0x0001020304050607 with sop.
  - beat1 = 0x08090A0B0C0D0E0F.
  - beat2 = 0x1011121300000000 with eop, empty=4, error=0.
  - msg_ready returns high the cycle after eop.
- msg_len=8, msg_error=1 -> single beat with sop=eop=1, empty=0, error=1; msg_ready low for exactly one cycle.
- msg_len=64, out_ready toggling 1,0,0,1,... -> exactly 8 transfers, data stable during every stall, eop on the 8th transfer, empty=0.
- msg_len=0, then msg_len=65 -> no out_valid for either; drop_pulse one cycle each; msg_ready stays 1.
- Two 9-byte messages back-to-back with msg_valid held high:
  - Each packet is 2 beats, the second with empty=7.
  - One idle cycle between the first packet's eop and the second packet's sop.
- reset_n asserted during beat 1 of a 3-beat packet -> out_valid=0 asynchronously. After release, a new 5-byte message emits one beat with sop, eop, empty=3.

Source files
------------

// File: rtl/avalon_st_msg_tx_if.sv
// ---------------------------------------------------------------------------
// avalon_st_msg_tx_if
//
// Signal bundle for the message transmitter: the parallel message handshake
// on one side and the Avalon-ST stream (readyLatency 0) on the other.
//
// Signals:
//   msg_valid / msg_ready   message offer / block can capture
//   msg_data                whole message, byte i = msg_data[8i+7:8i]
//   msg_len                 message length in bytes
//   msg_error               mark the packet errored
//   out_valid / out_ready   stream handshake
//   out_startofpacket       first beat of packet
//   out_endofpacket         last beat of packet
//   out_data                beat data, big-endian byte order
//   out_empty               unused bytes in the last beat
//   out_error               packet error, eop beat only
//
// Modports:
//   master  the transmitter (drives the stream and msg_ready)
//   slave   the environment (offers messages, sinks the stream)
// ---------------------------------------------------------------------------
interface avalon_st_msg_tx_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int MAX_BYTES   = 64,
    parameter int LEN_W       = 7
);
    logic                   msg_valid;
    logic                   msg_ready;
    logic [MAX_BYTES*8-1:0] msg_data;
    logic [LEN_W-1:0]       msg_len;
    logic                   msg_error;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_startofpacket;
    logic                   out_endofpacket;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [EMPTY_WIDTH-1:0] out_empty;
    logic                   out_error;

    modport master (
        input  msg_valid, msg_data, msg_len, msg_error, out_ready,
        output msg_ready, out_valid, out_startofpacket, out_endofpacket,
               out_data, out_empty, out_error
    );

    modport slave (
        output msg_valid, msg_data, msg_len, msg_error, out_ready,
        input  msg_ready, out_valid, out_startofpacket, out_endofpacket,
               out_data, out_empty, out_error
    );
endinterface

// File: rtl/avalon_st_msg_tx.sv
// ---------------------------------------------------------------------------
// avalon_st_msg_tx
//
// Avalon-ST source that captures one whole message per handshake and streams
// it out DATA_WIDTH/8 bytes per beat, big-endian (message byte 0 lands in the
// top byte lane of the first beat). readyLatency is 0.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset, synchronous release expected
//   bus         avalon_st_msg_tx_if.master: message handshake + stream
//   drop_pulse  one-cycle pulse when an illegal-length message is discarded
//   busy        high while a packet is being sent
// ---------------------------------------------------------------------------
module avalon_st_msg_tx #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int MAX_BYTES   = 64,
    parameter int LEN_W       = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_st_msg_tx_if.master    bus,
    output logic                  drop_pulse,
    output logic                  busy
);

    localparam int BPB       = DATA_WIDTH / 8;
    localparam int MAX_BEATS = MAX_BYTES / BPB;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int MSG_W     = MAX_BYTES * 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_q;
    logic [MSG_W-1:0]       msgData_q;
    logic [LEN_W-1:0]       msgLen_q;
    logic                   msgError_q;
    logic [BEAT_W-1:0]      beats_q;
    logic [BEAT_W-1:0]      beatIdx_q;
    logic [EMPTY_WIDTH-1:0] lastEmpty_q;

    logic                   outValid_q;
    logic                   outSop_q;
    logic                   outEop_q;
    logic [DATA_WIDTH-1:0]  outData_q;
    logic [EMPTY_WIDTH-1:0] outEmpty_q;
    logic                   outError_q;
    logic                   drop_q;

    logic                   lenLegal;
    logic [LEN_W:0]         lenRound;
    logic [BEAT_W-1:0]      capBeats;
    logic [LEN_W-1:0]       negLen;
    logic [EMPTY_WIDTH-1:0] capEmpty;
    logic [BEAT_W-1:0]      nextIdx;
    logic [BEAT_W-1:0]      lastIdx;
    logic                   onLast;
    logic                   nextIsLast;
    logic [DATA_WIDTH-1:0]  firstBeat;
    logic [DATA_WIDTH-1:0]  nextBeat;

    // Extract beat k of a message: byte 8k+j goes to lane j counted from the
    // top of the word; lanes past the message length are forced to zero so
    // stale bytes in the capture register never leak onto the bus.
    function automatic logic [DATA_WIDTH-1:0] packBeat(
        input logic [MSG_W-1:0]  data,
        input logic [LEN_W-1:0]  len,
        input logic [BEAT_W-1:0] k
    );
        logic [MSG_W-1:0]      shifted;
        logic [DATA_WIDTH-1:0] beat;
        int                    base;
        shifted = data >> (int'(k) * DATA_WIDTH);
        base    = int'(k) * BPB;
        beat    = '0;
        for (int j = 0; j < BPB; j++) begin
            if (base + j < int'(len)) begin
                beat[DATA_WIDTH-1-8*j -: 8] = shifted[8*j +: 8];
            end
        end
        return beat;
    endfunction

    // Capture-time arithmetic. Beat count is ceil(len/BPB); because BPB is a
    // power of two the padding in the last beat is simply (-len) mod BPB.
    assign lenLegal  = (bus.msg_len != '0) && (bus.msg_len <= LEN_W'(MAX_BYTES));
    assign lenRound  = {1'b0, bus.msg_len} + (LEN_W+1)'(BPB - 1);
    assign capBeats  = BEAT_W'(lenRound >> EMPTY_WIDTH);
    assign negLen    = -bus.msg_len;
    assign capEmpty  = negLen[EMPTY_WIDTH-1:0];
    assign firstBeat = packBeat(bus.msg_data, bus.msg_len, '0);

    // Look-ahead for the beat that follows the one currently on the bus, so
    // every stream output can be loaded straight into its register.
    assign nextIdx    = beatIdx_q + BEAT_W'(1);
    assign lastIdx    = beats_q - BEAT_W'(1);
    assign onLast     = (beatIdx_q == lastIdx);
    assign nextIsLast = (nextIdx == lastIdx);
    assign nextBeat   = packBeat(msgData_q, msgLen_q, nextIdx);

    // Control FSM with registered stream outputs. In SEND the bus registers
    // only move on an accepted beat, which keeps them stable under
    // backpressure and guarantees valid never drops without a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            msgData_q   <= '0;
            msgLen_q    <= '0;
            msgError_q  <= 1'b0;
            beats_q     <= '0;
            beatIdx_q   <= '0;
            lastEmpty_q <= '0;
            outValid_q  <= 1'b0;
            outSop_q    <= 1'b0;
            outEop_q    <= 1'b0;
            outData_q   <= '0;
            outEmpty_q  <= '0;
            outError_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.msg_valid) begin
                        if (lenLegal) begin
                            state_q     <= SEND;
                            msgData_q   <= bus.msg_data;
                            msgLen_q    <= bus.msg_len;
                            msgError_q  <= bus.msg_error;
                            beats_q     <= capBeats;
                            beatIdx_q   <= '0;
                            lastEmpty_q <= capEmpty;
                            outValid_q  <= 1'b1;
                            outSop_q    <= 1'b1;
                            outData_q   <= firstBeat;
                            if (capBeats == BEAT_W'(1)) begin
                                outEop_q   <= 1'b1;
                                outEmpty_q <= capEmpty;
                                outError_q <= bus.msg_error;
                            end else begin
                                outEop_q   <= 1'b0;
                                outEmpty_q <= '0;
                                outError_q <= 1'b0;
                            end
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (bus.out_ready) begin
                        if (onLast) begin
                            state_q    <= IDLE;
                            outValid_q <= 1'b0;
                            outSop_q   <= 1'b0;
                            outEop_q   <= 1'b0;
                            outData_q  <= '0;
                            outEmpty_q <= '0;
                            outError_q <= 1'b0;
                        end else begin
                            beatIdx_q <= nextIdx;
                            outSop_q  <= 1'b0;
                            outData_q <= nextBeat;
                            outEop_q  <= nextIsLast;
                            if (nextIsLast) begin
                                outEmpty_q <= lastEmpty_q;
                                outError_q <= msgError_q;
                            end else begin
                                outEmpty_q <= '0;
                                outError_q <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.msg_ready         = (state_q == IDLE);
    assign busy                  = (state_q == SEND);
    assign drop_pulse            = drop_q;
    assign bus.out_valid         = outValid_q;
    assign bus.out_startofpacket = outSop_q;
    assign bus.out_endofpacket   = outEop_q;
    assign bus.out_data          = outData_q;
    assign bus.out_empty         = outEmpty_q;
    assign bus.out_error         = outError_q;

endmodule
